reg_scoreboard: RTL and testbench

- Hazard controller for the decode stage that sits between fetch and the reg_sign register-bank/sign-extension block.
- Tracks one busy bit per architectural register and decides each cycle whether the fetched instruction may issue (read operand_a/operand_b) or must stall.
- Busy bits are set on issue of a register-writing instruction and cleared by writeback.
- Also counts outstanding writes, sequences fence/drain requests and counts stall cycles.

---
 rtl/reg_pkg.sv | 24 ++
 rtl/reg_scoreboard_if.sv | 35 +++
 rtl/reg_use_decode.sv | 47 ++++
 rtl/reg_scoreboard.sv | 112 +++++++++++
 tb/tb_reg_scoreboard.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_pkg.sv
// Shared definitions for the register scoreboard: RV32I opcodes,
// register-file geometry and the fence sequencer state encoding.
package reg_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FENCE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-side bundle of the scoreboard: instruction/writeback/fence
// requests in (master drives) and issue/status outputs (slave drives).
interface reg_scoreboard_if #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int STALL_CNT_W     = 16
);
   import reg_pkg::*;

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   logic                  instr_valid;
   logic [31:0]           instr_reg_fetch;
   logic                  issue_ready;
   logic                  issue_fire;
   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  fence_req;
   logic                  fence_done;
   logic [NUM_REGS-1:0]   busy_mask;
   logic [OUT_W-1:0]      outstanding;
   logic [STALL_CNT_W-1:0] stall_cycles;

   modport master (
      output instr_valid, instr_reg_fetch, wb_valid, wb_rd, fence_req,
      input  issue_ready, issue_fire, fence_done, busy_mask,
      input  outstanding, stall_cycles
   );

   modport slave (
      input  instr_valid, instr_reg_fetch, wb_valid, wb_rd, fence_req,
      output issue_ready, issue_fire, fence_done, busy_mask,
      output outstanding, stall_cycles
   );

endinterface

// File: rtl/reg_use_decode.sv
// Maps an RV32I word to its register fields and which of them it uses.
// Ports: instr_i in; rs1_o/rs2_o/rd_o and uses_rs1_o/uses_rs2_o/writes_rd_o out.
module reg_use_decode
   import reg_pkg::*;
(
   input  logic [31:0]           instr_i,
   output logic [REG_ADDR_W-1:0] rs1_o,
   output logic [REG_ADDR_W-1:0] rs2_o,
   output logic [REG_ADDR_W-1:0] rd_o,
   output logic                  uses_rs1_o,
   output logic                  uses_rs2_o,
   output logic                  writes_rd_o
);

   logic unused_bits;
   assign unused_bits = ^{instr_i[31:25], instr_i[14:12]};

   assign rs1_o = instr_i[19:15];
   assign rs2_o = instr_i[24:20];
   assign rd_o  = instr_i[11:7];

   always_comb begin
      uses_rs1_o  = 1'b0;
      uses_rs2_o  = 1'b0;
      writes_rd_o = 1'b0;
      case (instr_i[6:0])
         OP_R: begin
            uses_rs1_o  = 1'b1;
            uses_rs2_o  = 1'b1;
            writes_rd_o = 1'b1;
         end
         OP_I, OP_LOAD, OP_JALR: begin
            uses_rs1_o  = 1'b1;
            writes_rd_o = 1'b1;
         end
         OP_STORE, OP_BRANCH: begin
            uses_rs1_o = 1'b1;
            uses_rs2_o = 1'b1;
         end
         OP_LUI, OP_AUIPC, OP_JAL: begin
            writes_rd_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage hazard controller: per-register busy bits, in-flight write
// limit, fence drain sequencer and saturating stall counter.
// Ports: clk, rst (sync, active high); sb = reg_scoreboard_if slave bundle.
module reg_scoreboard
   import reg_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int WB_BYPASS       = 1,
   parameter int STALL_CNT_W     = 16
) (
   input logic            clk,
   input logic            rst,
   reg_scoreboard_if.slave sb
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [REG_ADDR_W-1:0] rs1, rs2, rd;
   logic                  uses_rs1, uses_rs2, writes_rd;

   reg_use_decode u_dec (
      .instr_i     (sb.instr_reg_fetch),
      .rs1_o       (rs1),
      .rs2_o       (rs2),
      .rd_o        (rd),
      .uses_rs1_o  (uses_rs1),
      .uses_rs2_o  (uses_rs2),
      .writes_rd_o (writes_rd)
   );

   state_t               state_q;
   logic [NUM_REGS-1:0]  busy_q, busy_d, eff_busy;
   logic [OUT_W-1:0]     outst_q, outst_d;
   logic [STALL_CNT_W-1:0] stall_q;
   logic                 done_q;
   logic                 hazard, at_limit, wb_hit;
   logic                 ready, fire, set_en;

   always_comb begin
      // A same-cycle writeback may release its register early.
      eff_busy = busy_q;
      if (WB_BYPASS != 0 && sb.wb_valid) eff_busy[sb.wb_rd] = 1'b0;

      hazard = (uses_rs1 && eff_busy[rs1]) ||
               (uses_rs2 && eff_busy[rs2]) ||
               (writes_rd && eff_busy[rd]);

      // x0 never busy, so a hit implies a real write retiring.
      wb_hit = sb.wb_valid && busy_q[sb.wb_rd];

      // A retiring write frees a slot for the incoming one.
      at_limit = writes_rd && (rd != '0) &&
                 (outst_q == OUT_W'(MAX_OUTSTANDING)) && !wb_hit;

      ready  = !rst && (state_q == ST_RUN) && !hazard && !at_limit;
      fire   = sb.instr_valid && ready;
      set_en = fire && writes_rd && (rd != '0);

      // Set after clear so a re-issued register stays busy.
      busy_d = busy_q;
      if (wb_hit) busy_d[sb.wb_rd] = 1'b0;
      if (set_en) busy_d[rd] = 1'b1;
      busy_d[0] = 1'b0;

      outst_d = outst_q;
      if (set_en && !wb_hit) outst_d = outst_q + 1'b1;
      else if (!set_en && wb_hit) outst_d = outst_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         busy_q  <= '0;
         outst_q <= '0;
         stall_q <= '0;
         done_q  <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         outst_q <= outst_d;
         done_q  <= 1'b0;
         if (sb.instr_valid && !ready && stall_q != '1)
            stall_q <= stall_q + 1'b1;
         case (state_q)
            ST_RUN: begin
               if (sb.fence_req) begin
                  if (outst_d != '0) state_q <= ST_FENCE;
                  else done_q <= 1'b1;
               end
            end
            ST_FENCE: begin
               if (outst_d == '0) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Hold until the request drops so it cannot retrigger.
               if (!sb.fence_req) state_q <= ST_RUN;
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign sb.issue_ready  = ready;
   assign sb.issue_fire   = fire;
   assign sb.fence_done   = done_q;
   assign sb.busy_mask    = busy_q;
   assign sb.outstanding  = outst_q;
   assign sb.stall_cycles = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scenario bench for reg_scoreboard: expectations are queued as stimulus
// is applied and popped when the corresponding output is sampled.
module tb_reg_scoreboard;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   always #5 clk = ~clk;

   reg_scoreboard_if #(.MAX_OUTSTANDING(4), .STALL_CNT_W(16)) sb ();

   reg_scoreboard #(
      .MAX_OUTSTANDING (4),
      .WB_BYPASS       (1),
      .STALL_CNT_W     (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb)
   );

   function automatic logic [31:0] addi(input logic [4:0] rd);
      return {12'd1, 5'd0, 3'd0, rd, 7'b0010011};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sb.instr_valid = 1'b1;
      sb.instr_reg_fetch = 32'h002081B3;
      sb.wb_valid = 1'b1;
      sb.wb_rd = 5'd5;
      sb.fence_req = 1'b0;
      #2;
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL rst_ready0 got=%b exp=%b", sb.issue_ready, e[0]); end
      tick();
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL rst_ready1 got=%b exp=%b", sb.issue_ready, e[0]); end
      tick();
      rst = 1'b0;
      sb.instr_valid = 1'b0;
      sb.wb_valid = 1'b0;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      e = exp_q.pop_front(); n_chk++;
      if (sb.busy_mask !== e) begin n_err++; $display("FAIL rst_busy got=%h exp=%h", sb.busy_mask, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.outstanding) !== e) begin n_err++; $display("FAIL rst_outst got=%0d exp=%0d", sb.outstanding, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.stall_cycles) !== e) begin n_err++; $display("FAIL rst_stall got=%0d exp=%0d", sb.stall_cycles, e); end
      e = exp_q.pop_front(); n_chk++;
      if (sb.fence_done !== e[0]) begin n_err++; $display("FAIL rst_fdone got=%b exp=%b", sb.fence_done, e[0]); end
   endtask

   task automatic test_raw();
      sb.instr_valid = 1'b1;
      sb.instr_reg_fetch = 32'h002081B3;
      exp_q.push_back(32'h8); exp_q.push_back(32'd1);
      tick();
      e = exp_q.pop_front(); n_chk++;
      if (sb.busy_mask !== e) begin n_err++; $display("FAIL raw_busy got=%h exp=%h", sb.busy_mask, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.outstanding) !== e) begin n_err++; $display("FAIL raw_outst got=%0d exp=%0d", sb.outstanding, e); end
      sb.instr_reg_fetch = 32'h00418233;
      #1;
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL raw_stall_ready got=%b exp=%b", sb.issue_ready, e[0]); end
      exp_q.push_back(32'd3);
      repeat (3) tick();
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.stall_cycles) !== e) begin n_err++; $display("FAIL raw_stall_cnt got=%0d exp=%0d", sb.stall_cycles, e); end
      sb.wb_valid = 1'b1;
      sb.wb_rd = 5'd3;
      #1;
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL raw_bypass_ready got=%b exp=%b", sb.issue_ready, e[0]); end
      exp_q.push_back(32'h10); exp_q.push_back(32'd1); exp_q.push_back(32'd3);
      tick();
      sb.instr_valid = 1'b0;
      sb.wb_valid = 1'b0;
      e = exp_q.pop_front(); n_chk++;
      if (sb.busy_mask !== e) begin n_err++; $display("FAIL raw_busy2 got=%h exp=%h", sb.busy_mask, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.outstanding) !== e) begin n_err++; $display("FAIL raw_outst2 got=%0d exp=%0d", sb.outstanding, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.stall_cycles) !== e) begin n_err++; $display("FAIL raw_stall_hold got=%0d exp=%0d", sb.stall_cycles, e); end
      sb.wb_valid = 1'b1;
      sb.wb_rd = 5'd4;
      tick();
      sb.wb_valid = 1'b0;
   endtask

   task automatic test_x0_store();
      sb.instr_valid = 1'b1;
      sb.instr_reg_fetch = 32'h00208033;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      tick();
      e = exp_q.pop_front(); n_chk++;
      if (sb.busy_mask !== e) begin n_err++; $display("FAIL x0_busy got=%h exp=%h", sb.busy_mask, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.outstanding) !== e) begin n_err++; $display("FAIL x0_outst got=%0d exp=%0d", sb.outstanding, e); end
      sb.instr_reg_fetch = addi(5'd5);
      exp_q.push_back(32'h20);
      tick();
      e = exp_q.pop_front(); n_chk++;
      if (sb.busy_mask !== e) begin n_err++; $display("FAIL st_x5_busy got=%h exp=%h", sb.busy_mask, e); end
      sb.instr_reg_fetch = 32'h00532023;
      exp_q.push_back(32'd0);
      repeat (2) tick();
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL st_stall got=%b exp=%b", sb.issue_ready, e[0]); end
      sb.wb_valid = 1'b1;
      sb.wb_rd = 5'd5;
      #1;
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_fire !== e[0]) begin n_err++; $display("FAIL st_fire got=%b exp=%b", sb.issue_fire, e[0]); end
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd5);
      tick();
      sb.instr_valid = 1'b0;
      sb.wb_valid = 1'b0;
      e = exp_q.pop_front(); n_chk++;
      if (sb.busy_mask !== e) begin n_err++; $display("FAIL st_busy got=%h exp=%h", sb.busy_mask, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.outstanding) !== e) begin n_err++; $display("FAIL st_outst got=%0d exp=%0d", sb.outstanding, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.stall_cycles) !== e) begin n_err++; $display("FAIL st_stall_cnt got=%0d exp=%0d", sb.stall_cycles, e); end
   endtask

   task automatic test_outstanding();
      sb.instr_valid = 1'b1;
      for (int r = 1; r <= 4; r++) begin
         sb.instr_reg_fetch = addi(5'(r));
         tick();
      end
      exp_q.push_back(32'h1E); exp_q.push_back(32'd4);
      e = exp_q.pop_front(); n_chk++;
      if (sb.busy_mask !== e) begin n_err++; $display("FAIL lim_busy got=%h exp=%h", sb.busy_mask, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.outstanding) !== e) begin n_err++; $display("FAIL lim_outst got=%0d exp=%0d", sb.outstanding, e); end
      sb.instr_reg_fetch = addi(5'd5);
      #1;
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL lim_block got=%b exp=%b", sb.issue_ready, e[0]); end
      sb.wb_valid = 1'b1;
      sb.wb_rd = 5'd1;
      #1;
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL lim_free got=%b exp=%b", sb.issue_ready, e[0]); end
      exp_q.push_back(32'h3C); exp_q.push_back(32'd4);
      tick();
      sb.instr_valid = 1'b0;
      e = exp_q.pop_front(); n_chk++;
      if (sb.busy_mask !== e) begin n_err++; $display("FAIL lim_busy2 got=%h exp=%h", sb.busy_mask, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.outstanding) !== e) begin n_err++; $display("FAIL lim_outst2 got=%0d exp=%0d", sb.outstanding, e); end
      for (int r = 2; r <= 5; r++) begin
         sb.wb_rd = 5'(r);
         tick();
      end
      sb.wb_valid = 1'b0;
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.outstanding) !== e) begin n_err++; $display("FAIL lim_drain got=%0d exp=%0d", sb.outstanding, e); end
   endtask

   task automatic test_fence();
      sb.instr_valid = 1'b1;
      sb.instr_reg_fetch = addi(5'd7);
      tick();
      sb.instr_reg_fetch = addi(5'd8);
      tick();
      sb.instr_valid = 1'b0;
      sb.instr_reg_fetch = 32'h0;
      sb.fence_req = 1'b1;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      tick();
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL fn_ready got=%b exp=%b", sb.issue_ready, e[0]); end
      e = exp_q.pop_front(); n_chk++;
      if (sb.fence_done !== e[0]) begin n_err++; $display("FAIL fn_early got=%b exp=%b", sb.fence_done, e[0]); end
      sb.wb_valid = 1'b1;
      sb.wb_rd = 5'd7;
      exp_q.push_back(32'd0);
      tick();
      e = exp_q.pop_front(); n_chk++;
      if (sb.fence_done !== e[0]) begin n_err++; $display("FAIL fn_mid got=%b exp=%b", sb.fence_done, e[0]); end
      sb.wb_rd = 5'd8;
      exp_q.push_back(32'd1); exp_q.push_back(32'd0);
      tick();
      sb.wb_valid = 1'b0;
      e = exp_q.pop_front(); n_chk++;
      if (sb.fence_done !== e[0]) begin n_err++; $display("FAIL fn_pulse got=%b exp=%b", sb.fence_done, e[0]); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.outstanding) !== e) begin n_err++; $display("FAIL fn_outst got=%0d exp=%0d", sb.outstanding, e); end
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(32'd0); exp_q.push_back(32'd0);
         tick();
         e = exp_q.pop_front(); n_chk++;
         if (sb.fence_done !== e[0]) begin n_err++; $display("FAIL fn_hold_done%0d got=%b exp=%b", k, sb.fence_done, e[0]); end
         e = exp_q.pop_front(); n_chk++;
         if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL fn_hold_ready%0d got=%b exp=%b", k, sb.issue_ready, e[0]); end
      end
      sb.fence_req = 1'b0;
      exp_q.push_back(32'd1);
      tick();
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL fn_run got=%b exp=%b", sb.issue_ready, e[0]); end
   endtask

   task automatic test_spurious_and_reset();
      sb.wb_valid = 1'b1;
      sb.wb_rd = 5'd9;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      tick();
      sb.wb_rd = 5'd0;
      tick();
      sb.wb_valid = 1'b0;
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.outstanding) !== e) begin n_err++; $display("FAIL spur_outst got=%0d exp=%0d", sb.outstanding, e); end
      e = exp_q.pop_front(); n_chk++;
      if (sb.busy_mask !== e) begin n_err++; $display("FAIL spur_busy got=%h exp=%h", sb.busy_mask, e); end
      sb.instr_valid = 1'b1;
      sb.instr_reg_fetch = addi(5'd7);
      tick();
      sb.instr_valid = 1'b0;
      sb.instr_reg_fetch = 32'h0;
      sb.fence_req = 1'b1;
      exp_q.push_back(32'd0);
      tick();
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL mid_fence got=%b exp=%b", sb.issue_ready, e[0]); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.fence_req = 1'b0;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_q.push_back(32'd1); exp_q.push_back(32'd0);
      e = exp_q.pop_front(); n_chk++;
      if (sb.busy_mask !== e) begin n_err++; $display("FAIL rr_busy got=%h exp=%h", sb.busy_mask, e); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.outstanding) !== e) begin n_err++; $display("FAIL rr_outst got=%0d exp=%0d", sb.outstanding, e); end
      #1;
      e = exp_q.pop_front(); n_chk++;
      if (sb.issue_ready !== e[0]) begin n_err++; $display("FAIL rr_run got=%b exp=%b", sb.issue_ready, e[0]); end
      e = exp_q.pop_front(); n_chk++;
      if (32'(sb.stall_cycles) !== e) begin n_err++; $display("FAIL rr_stall got=%0d exp=%0d", sb.stall_cycles, e); end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_x0_store();
      test_outstanding();
      test_fence();
      test_spurious_and_reset();
      if (exp_q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
